// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: transmitter state encoding,
// line levels and small sizing helpers. The serial receiver uses it too.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clks_per_bit);
        return (data_w + 32'd2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake plus serial line status between a producer and serial_tx.
interface serial_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              tx_busy;
    logic              tx_done;

    // Producer side: offers words, observes line and status.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_out,
        input  tx_busy,
        input  tx_done
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps. tick is high in the
// last cycle of each bit period, so the owner advances on that edge.
// clear restarts the period at count 0 on the next cycle.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned     CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             tick_r;

    // Next count: restart on clear or wrap, otherwise increment.
    always_comb begin
        count_nxt_s = count_r;
        if (clear || (count_r == LAST)) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + CNT_W'(1);
        end
    end

    // Count register and registered wrap flag (flag tracks "count is LAST").
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
            tick_r  <= (LAST == '0);
        end else begin
            count_r <= count_nxt_s;
            tick_r  <= (count_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter. Idle-high line; each frame is one
// start bit (0), DATA_W data bits LSB first, one stop bit (1), each held for
// CLKS_PER_BIT clocks. All outputs come straight from flops.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus
);
    localparam int unsigned      IDX_W    = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 32'd1);

    tx_state_t         state_r;
    logic [DATA_W-1:0] shift_r;
    logic [IDX_W-1:0]  idx_r;
    logic              tx_out_r;
    logic              busy_r;
    logic              done_r;
    logic              ready_r;

    logic              accept_s;
    logic              tick_s;
    logic [DATA_W-1:0] shift_nxt_s;

    assign accept_s    = bus.tx_valid && ready_r;
    assign shift_nxt_s = shift_r >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (accept_s),
        .tick  (tick_s)
    );

    // Frame FSM: sequences start/data/stop bits and registers every output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            idx_r    <= '0;
            tx_out_r <= IDLE_LVL;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r  <= bus.tx_data;
                        idx_r    <= '0;
                        state_r  <= START;
                        tx_out_r <= START_LVL;
                        busy_r   <= 1'b1;
                        ready_r  <= 1'b0;
                    end else begin
                        tx_out_r <= IDLE_LVL;
                        busy_r   <= 1'b0;
                        ready_r  <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_r  <= DATA;
                        tx_out_r <= shift_r[0];
                    end else begin
                        tx_out_r <= START_LVL;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (idx_r == LAST_IDX) begin
                            state_r  <= STOP;
                            tx_out_r <= STOP_LVL;
                        end else begin
                            shift_r  <= shift_nxt_s;
                            tx_out_r <= shift_nxt_s[0];
                            idx_r    <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        tx_out_r <= shift_r[0];
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        state_r  <= IDLE;
                        tx_out_r <= IDLE_LVL;
                        busy_r   <= 1'b0;
                        ready_r  <= 1'b1;
                        done_r   <= 1'b1;
                    end else begin
                        tx_out_r <= STOP_LVL;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tx_out_r <= IDLE_LVL;
                    busy_r   <= 1'b0;
                    ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_ready = ready_r;
    assign bus.tx_out   = tx_out_r;
    assign bus.tx_busy  = busy_r;
    assign bus.tx_done  = done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-clock instance and a
// 5-bit/1-clock instance, line shapes and decoded words checked per cycle.
module tb_serial_tx;

    logic clk;
    logic reset_a;
    logic reset_b;

    int n_cmp = 0;
    int n_mis = 0;

    serial_tx_if #(.DATA_W(8)) bus_a ();
    serial_tx_if #(.DATA_W(5)) bus_b ();

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    serial_tx #(.DATA_W(5), .CLKS_PER_BIT(1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first start-bit cycle of dut_a; checks 40 frame cycles,
    // decodes mid-bit samples, and ends in the first idle cycle (tx_done).
    task automatic run_frame_a(input logic [7:0] w, output logic [7:0] dec);
        dec = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            int   bp;
            logic e;
            bp = (k - 1) / 4;
            if (bp == 0)      e = 1'b0;
            else if (bp == 9) e = 1'b1;
            else              e = w[bp-1];
            check("a_line", 32'(bus_a.tx_out), 32'(e));
            check("a_ready_busy", 32'({bus_a.tx_ready, bus_a.tx_busy}), 32'h1);
            check("a_done_in_frame", 32'(bus_a.tx_done), 32'h0);
            if (bp >= 1 && bp <= 8 && ((k - 1) % 4) == 2) dec[bp-1] = bus_a.tx_out;
            step();
        end
        check("a_done_pulse", 32'(bus_a.tx_done), 32'h1);
        check("a_ready_at_done", 32'(bus_a.tx_ready), 32'h1);
        check("a_busy_at_done", 32'(bus_a.tx_busy), 32'h0);
        check("a_idle_line", 32'(bus_a.tx_out), 32'h1);
    endtask

    initial begin
        logic [7:0] dec;
        logic [6:0] exp_b;

        reset_a = 1'b0;
        reset_b = 1'b0;
        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = 8'h00;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = 5'h00;
        step();
        step();

        // Reset state
        check("rst_a_out", 32'(bus_a.tx_out), 32'h1);
        check("rst_a_ready", 32'(bus_a.tx_ready), 32'h1);
        check("rst_a_busy", 32'(bus_a.tx_busy), 32'h0);
        check("rst_a_done", 32'(bus_a.tx_done), 32'h0);
        check("rst_b_out", 32'(bus_b.tx_out), 32'h1);
        check("rst_b_ready", 32'(bus_b.tx_ready), 32'h1);
        reset_a = 1'b1;
        reset_b = 1'b1;
        step();
        step();
        check("idle_a_out", 32'(bus_a.tx_out), 32'h1);

        // Single frame 8'hA5
        bus_a.tx_data  = 8'hA5;
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        run_frame_a(8'hA5, dec);
        check("a5_decode", 32'(dec), 32'hA5);
        step();
        check("a5_done_once", 32'(bus_a.tx_done), 32'h0);
        step();

        // Back-to-back 8'h00 then 8'hFF with tx_valid held high
        bus_a.tx_data  = 8'h00;
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_data = 8'hFF;
        run_frame_a(8'h00, dec);
        check("b2b_first_decode", 32'(dec), 32'h00);
        step();
        bus_a.tx_valid = 1'b0;
        run_frame_a(8'hFF, dec);
        check("b2b_second_decode", 32'(dec), 32'hFF);
        step();
        step();

        // Data stability: 8'h81 sent while tx_data changes to 8'h3C
        bus_a.tx_data  = 8'h81;
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = 8'h3C;
        run_frame_a(8'h81, dec);
        check("stable_decode", 32'(dec), 32'h81);
        step();

        // Reset mid-frame for 3 cycles
        bus_a.tx_data  = 8'h5A;
        bus_a.tx_valid = 1'b1;
        step();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_busy", 32'(bus_a.tx_busy), 32'h1);
        reset_a = 1'b0;
        step();
        check("midrst_out", 32'(bus_a.tx_out), 32'h1);
        check("midrst_ready", 32'(bus_a.tx_ready), 32'h1);
        check("midrst_busy", 32'(bus_a.tx_busy), 32'h0);
        check("midrst_done", 32'(bus_a.tx_done), 32'h0);
        step();
        step();
        reset_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            check("post_rst_out", 32'(bus_a.tx_out), 32'h1);
            check("post_rst_done", 32'(bus_a.tx_done), 32'h0);
            check("post_rst_ready", 32'(bus_a.tx_ready), 32'h1);
            step();
        end

        // Handshake and reset in the same cycle: word dropped
        reset_a        = 1'b0;
        bus_a.tx_data  = 8'hFF;
        bus_a.tx_valid = 1'b1;
        step();
        reset_a        = 1'b1;
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("rsths_out", 32'(bus_a.tx_out), 32'h1);
            check("rsths_busy", 32'(bus_a.tx_busy), 32'h0);
            step();
        end

        // CLKS_PER_BIT=1, DATA_W=5, 5'b10110 -> 0,0,1,1,0,1,1
        exp_b = 7'b1101100;
        bus_b.tx_data  = 5'b10110;
        bus_b.tx_valid = 1'b1;
        step();
        bus_b.tx_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("b_line", 32'(bus_b.tx_out), 32'(exp_b[k]));
            check("b_busy", 32'(bus_b.tx_busy), 32'h1);
            check("b_done_in_frame", 32'(bus_b.tx_done), 32'h0);
            step();
        end
        check("b_done_pulse", 32'(bus_b.tx_done), 32'h1);
        check("b_idle_line", 32'(bus_b.tx_out), 32'h1);
        check("b_ready", 32'(bus_b.tx_ready), 32'h1);
        step();
        check("b_done_once", 32'(bus_b.tx_done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter: accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single output line as an idle-high frame (one start bit at 0, data LSB first, one stop bit at 1). Each bit is held for CLKS_PER_BIT clocks. It is the launching end for the serial capture flops and sits between a word producer and a one-wire link in the same clock domain.

## Interface

- DATA_W, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- tx_data  input  DATA_W  word to send; sampled only on handshake
- tx_valid  input  1  producer has a word
- tx_ready  output  1  transmitter can accept a word
- tx_out  output  1  serial line, idle high
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse at end of frame

## Operation

- States: IDLE, START, DATA, STOP.
- IDLE: tx_ready=1, tx_busy=0, tx_out=1. On tx_valid&&tx_ready, latch tx_data into the shift register, clear bit timer and bit index, go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_out = shift_reg[0]; after CLKS_PER_BIT cycles shift right. After DATA_W bits go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE with tx_done=1 for that one cycle.
- tx_ready=1 only in IDLE. tx_busy=1 in START/DATA/STOP.
- tx_data changes while busy are ignored; the latched word is sent unchanged.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps; width is $clog2(CLKS_PER_BIT) bits, min 1. Bit index width is $clog2(DATA_W) bits, min 1.
- tx_valid deasserted in IDLE: stay in IDLE, line high indefinitely.

## Timing

- Reset values (cycle after reset sampled low): state IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, shift register and counters 0.
- Reset mid-frame aborts at the next edge: line returns high, no tx_done pulse. Reset overrides a handshake in the same cycle; the word is dropped.
- Handshake at edge N → tx_out=0 from cycle N+1 (registered output, 1-cycle latency).
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- tx_done and tx_ready are both high in the first IDLE cycle after STOP. If tx_valid is held high, the next word is accepted in that cycle. Back-to-back frames are separated by exactly one idle-high cycle.
- CLKS_PER_BIT=1: each bit lasts one cycle; no timer stall.
- Outputs are registered; no combinational path from tx_valid or tx_data to tx_out. tx_ready is decoded from registered state.

## Structure

- Package serial_pkg: typedef enum tx_state_t {IDLE, START, DATA, STOP}; localparams for line levels IDLE_LVL=1'b1, START_LVL=1'b0, STOP_LVL=1'b1. The future serial receiver shares this package.
- Sub-module bit_timer: parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick, one cycle when the count wraps. Reused by the receiver.

## Test plan

- Reset: hold reset=0 for 3 cycles mid-frame, then release → tx_out=1, tx_ready=1, tx_busy=0, tx_done never pulses.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, tx_data=8'hA5 → line shows 0 (4 cycles), then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles). tx_done pulses at cycle 41 after the handshake edge. A reference receiver decodes 8'hA5.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF → second start bit begins exactly 1 idle cycle after the first stop bit. Both words decode correctly.
- Data stability: change tx_data to 8'h3C during a frame of 8'h81 → 8'h81 transmitted. tx_ready=0 throughout the frame.
- CLKS_PER_BIT=1, DATA_W=5, tx_data=5'b10110 → frame 0,0,1,1,0,1,1 on consecutive cycles. Frame is 7 cycles.
- Handshake and reset in the same cycle (reset=0, tx_valid=1) → no frame starts. tx_out stays 1.
